// File: rtl/alu_dispatch.sv
// Request/response sequencer in front of a registered ALU: issues one op, captures result and PSR, counts completions.
// Optional macro ALU_DISPATCH_ILLEGAL_TRAP_EN answers illegal opcodes locally with an error response.
module alu_dispatch #(
    parameter int unsigned Bits = 12,
    parameter int unsigned Ops  = 4,
    parameter int unsigned CntW = 16
) (
    input  logic            iclock,
    input  logic            ireset,
    input  logic            ireq_valid,
    output logic            oreq_ready,
    input  logic [Ops-1:0]  ireq_op,
    input  logic [Bits-1:0] ireq_a,
    input  logic [Bits-1:0] ireq_b,
    output logic [Ops-1:0]  oalu_op,
    output logic [Bits-1:0] oalu_a,
    output logic [Bits-1:0] oalu_b,
    input  logic [Bits-1:0] ialu_out,
    input  logic [4:0]      ialu_psr,
    output logic            ores_valid,
    input  logic            ires_ready,
    output logic [Bits-1:0] ores_data,
    output logic [4:0]      ores_psr,
    output logic            ores_err,
    output logic [CntW-1:0] oops_count
);

    localparam logic [Ops-1:0] OP_NOP = Ops'(4'b0000);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            req_ready_nxt;
    logic            res_valid_nxt;
    logic [Ops-1:0]  alu_op_nxt;
    logic [Bits-1:0] alu_a_nxt;
    logic [Bits-1:0] alu_b_nxt;
    logic [Bits-1:0] res_data_nxt;
    logic [4:0]      res_psr_nxt;
    logic            res_err_nxt;
    logic [CntW-1:0] ops_count_nxt;
    logic            trap_op;

`ifdef ALU_DISPATCH_ILLEGAL_TRAP_EN
    localparam logic [Ops-1:0] OP_ADD = Ops'(4'b0100);
    localparam logic [Ops-1:0] OP_MUL = Ops'(4'b0101);
    localparam logic [Ops-1:0] OP_CMP = Ops'(4'b0110);
    localparam logic [Ops-1:0] OP_SHF = Ops'(4'b0111);
    localparam logic [Ops-1:0] OP_ROT = Ops'(4'b1000);

    // Opcodes outside the legal set never reach the ALU.
    assign trap_op = !((ireq_op == OP_ADD) || (ireq_op == OP_MUL) || (ireq_op == OP_CMP) ||
                       (ireq_op == OP_SHF) || (ireq_op == OP_ROT));
`else
    assign trap_op = 1'b0;
`endif

    // State register
    always_ff @(posedge iclock) begin
        if (ireset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_nxt     = state;
        alu_op_nxt    = OP_NOP;
        alu_a_nxt     = oalu_a;
        alu_b_nxt     = oalu_b;
        res_data_nxt  = ores_data;
        res_psr_nxt   = ores_psr;
        res_err_nxt   = ores_err;
        ops_count_nxt = oops_count;
        req_ready_nxt = 1'b0;
        res_valid_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (ireq_valid && oreq_ready) begin
                    if (trap_op) begin
                        state_nxt    = RESP;
                        res_data_nxt = '0;
                        res_psr_nxt  = '0;
                        res_err_nxt  = 1'b1;
                    end else begin
                        state_nxt   = ISSUE;
                        alu_op_nxt  = ireq_op;
                        alu_a_nxt   = ireq_a;
                        alu_b_nxt   = ireq_b;
                        res_err_nxt = 1'b0;
                    end
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                // ALU sampled at the end of ISSUE, so its output is valid now.
                res_data_nxt = ialu_out;
                res_psr_nxt  = ialu_psr;
                state_nxt    = RESP;
            end
            RESP: begin
                if (ires_ready) begin
                    ops_count_nxt = oops_count + CntW'(1);
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        req_ready_nxt = (state_nxt == IDLE);
        res_valid_nxt = (state_nxt == RESP);
    end

    // Output registers
    always_ff @(posedge iclock) begin
        if (ireset) begin
            oreq_ready <= 1'b1;
            ores_valid <= 1'b0;
            oalu_op    <= OP_NOP;
            oalu_a     <= '0;
            oalu_b     <= '0;
            ores_data  <= '0;
            ores_psr   <= '0;
            ores_err   <= 1'b0;
            oops_count <= '0;
        end else begin
            oreq_ready <= req_ready_nxt;
            ores_valid <= res_valid_nxt;
            oalu_op    <= alu_op_nxt;
            oalu_a     <= alu_a_nxt;
            oalu_b     <= alu_b_nxt;
            ores_data  <= res_data_nxt;
            ores_psr   <= res_psr_nxt;
            ores_err   <= res_err_nxt;
            oops_count <= ops_count_nxt;
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a behavioural stand-in for the registered ALU.
// A second instance with a 2-bit counter checks the completion-counter wrap.
module tb_alu_dispatch;

    logic        clk = 1'b0;
    logic        ireset;
    logic        ireq_valid;
    logic [3:0]  ireq_op;
    logic [11:0] ireq_a;
    logic [11:0] ireq_b;
    logic        ires_ready;

    logic        oreq_ready;
    logic [3:0]  oalu_op;
    logic [11:0] oalu_a;
    logic [11:0] oalu_b;
    logic        ores_valid;
    logic [11:0] ores_data;
    logic [4:0]  ores_psr;
    logic        ores_err;
    logic [15:0] oops_count;

    logic        w_req_ready;
    logic [3:0]  w_alu_op;
    logic [11:0] w_alu_a;
    logic [11:0] w_alu_b;
    logic        w_res_valid;
    logic [11:0] w_res_data;
    logic [4:0]  w_res_psr;
    logic        w_res_err;
    logic [1:0]  w_ops_count;

    logic [11:0] alu_out = 12'h000;
    logic [4:0]  alu_psr = 5'b00000;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_dispatch #(.Bits(12), .Ops(4), .CntW(16)) dut (
        .iclock(clk), .ireset(ireset),
        .ireq_valid(ireq_valid), .oreq_ready(oreq_ready),
        .ireq_op(ireq_op), .ireq_a(ireq_a), .ireq_b(ireq_b),
        .oalu_op(oalu_op), .oalu_a(oalu_a), .oalu_b(oalu_b),
        .ialu_out(alu_out), .ialu_psr(alu_psr),
        .ores_valid(ores_valid), .ires_ready(ires_ready),
        .ores_data(ores_data), .ores_psr(ores_psr), .ores_err(ores_err),
        .oops_count(oops_count)
    );

    alu_dispatch #(.Bits(12), .Ops(4), .CntW(2)) dut_wrap (
        .iclock(clk), .ireset(ireset),
        .ireq_valid(ireq_valid), .oreq_ready(w_req_ready),
        .ireq_op(ireq_op), .ireq_a(ireq_a), .ireq_b(ireq_b),
        .oalu_op(w_alu_op), .oalu_a(w_alu_a), .oalu_b(w_alu_b),
        .ialu_out(alu_out), .ialu_psr(alu_psr),
        .ores_valid(w_res_valid), .ires_ready(ires_ready),
        .ores_data(w_res_data), .ores_psr(w_res_psr), .ores_err(w_res_err),
        .oops_count(w_ops_count)
    );

    // Stand-in ALU: registered, holds on NOP/illegal; ADD PSR pattern reproduces the reference vectors.
    function automatic logic [16:0] alu_eval(input logic [3:0] op, input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        logic [23:0] m;
        logic [11:0] r;
        logic [4:0]  p;
        s = 13'(a) + 13'(b);
        m = 24'(a) * 24'(b);
        r = 12'h000;
        case (op)
            4'b0101: r = m[11:0];
            4'b0110: r = a - b;
            4'b0111: r = {a[10:0], 1'b0};
            4'b1000: r = {a[10:0], a[11]};
            default: r = s[11:0];
        endcase
        if (op == 4'b0100) p = {1'b0, 3'b111, s[12]};
        else               p = {r[11], (r == 12'h000), 3'b000};
        return {p, r};
    endfunction

    always @(posedge clk) begin
        if (oalu_op inside {4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000})
            {alu_psr, alu_out} <= alu_eval(oalu_op, oalu_a, oalu_b);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge where the response is first valid.
    task automatic issue(input string tag, input logic [3:0] op, input logic [11:0] a, input logic [11:0] b);
        chk({tag, "_req_ready"}, 32'(oreq_ready), 32'd1);
        ireq_valid = 1'b1;
        ireq_op    = op;
        ireq_a     = a;
        ireq_b     = b;
        @(negedge clk);
        ireq_valid = 1'b0;
        chk({tag, "_issue_op"}, 32'(oalu_op), 32'(op));
        chk({tag, "_issue_a"}, 32'(oalu_a), 32'(a));
        chk({tag, "_issue_b"}, 32'(oalu_b), 32'(b));
        chk({tag, "_busy"}, 32'(oreq_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_wait_nop"}, 32'(oalu_op), 32'd0);
        chk({tag, "_wait_novalid"}, 32'(ores_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(ores_valid), 32'd1);
    endtask

    logic [3:0]  v_op   [4] = '{4'b0100, 4'b0110, 4'b1000, 4'b0100};
    logic [11:0] v_a    [4] = '{12'h007, 12'h005, 12'h801, 12'hFFF};
    logic [11:0] v_b    [4] = '{12'h009, 12'h005, 12'h000, 12'h001};
    logic [11:0] v_data [4] = '{12'h010, 12'h000, 12'h003, 12'h000};
    logic [4:0]  v_psr  [4] = '{5'b01110, 5'b01000, 5'b00000, 5'b01111};
    logic [1:0]  v_wcnt [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ireset     = 1'b1;
        ireq_valid = 1'b0;
        ireq_op    = 4'h0;
        ireq_a     = 12'h000;
        ireq_b     = 12'h000;
        ires_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(oreq_ready), 32'd1);
        chk("rst_res_valid", 32'(ores_valid), 32'd0);
        chk("rst_data", 32'(ores_data), 32'd0);
        chk("rst_psr", 32'(ores_psr), 32'd0);
        chk("rst_err", 32'(ores_err), 32'd0);
        chk("rst_count", 32'(oops_count), 32'd0);
        chk("rst_alu_op", 32'(oalu_op), 32'd0);
        chk("rst_alu_a", 32'(oalu_a), 32'd0);
        ireset = 1'b0;

        // ADD 5+3
        issue("add1", 4'b0100, 12'h005, 12'h003);
        chk("add1_data", 32'(ores_data), 32'h008);
        chk("add1_psr", 32'(ores_psr), 32'b01110);
        chk("add1_err", 32'(ores_err), 32'd0);
        @(negedge clk);
        chk("add1_count", 32'(oops_count), 32'd1);
        chk("add1_done", 32'(ores_valid), 32'd0);

        // ADD with carry out
        issue("add2", 4'b0100, 12'h800, 12'h800);
        chk("add2_data", 32'(ores_data), 32'h000);
        chk("add2_psr", 32'(ores_psr), 32'b01111);
        @(negedge clk);
        chk("add2_count", 32'(oops_count), 32'd2);

        // MUL with response back-pressure and a stray request that must be ignored
        ires_ready = 1'b0;
        issue("mul", 4'b0101, 12'h003, 12'h004);
        for (int i = 0; i < 5; i++) begin
            chk("mul_hold_valid", 32'(ores_valid), 32'd1);
            chk("mul_hold_data", 32'(ores_data), 32'h00C);
            chk("mul_hold_psr", 32'(ores_psr), 32'b00000);
            chk("mul_hold_ready", 32'(oreq_ready), 32'd0);
            chk("mul_hold_nop", 32'(oalu_op), 32'd0);
            ireq_valid = (i == 1);
            ireq_op    = 4'b0100;
            @(negedge clk);
        end
        ireq_valid = 1'b0;
        chk("mul_count_held", 32'(oops_count), 32'd2);
        ires_ready = 1'b1;
        @(negedge clk);
        chk("mul_done", 32'(ores_valid), 32'd0);
        chk("mul_ready_back", 32'(oreq_ready), 32'd1);
        chk("mul_count", 32'(oops_count), 32'd3);

        // Illegal opcode
`ifdef ALU_DISPATCH_ILLEGAL_TRAP_EN
        ireq_valid = 1'b1;
        ireq_op    = 4'b1111;
        ireq_a     = 12'h123;
        ireq_b     = 12'h456;
        @(negedge clk);
        ireq_valid = 1'b0;
        chk("trap_nop", 32'(oalu_op), 32'd0);
        chk("trap_valid", 32'(ores_valid), 32'd1);
        chk("trap_err", 32'(ores_err), 32'd1);
        chk("trap_data", 32'(ores_data), 32'h000);
        chk("trap_psr", 32'(ores_psr), 32'd0);
`else
        issue("ill", 4'b1111, 12'h123, 12'h456);
        chk("ill_err", 32'(ores_err), 32'd0);
        chk("ill_data", 32'(ores_data), 32'h00C);
        chk("ill_psr", 32'(ores_psr), 32'd0);
`endif
        @(negedge clk);
        chk("ill_count", 32'(oops_count), 32'd4);

        // Reset while in WAIT
        ireq_valid = 1'b1;
        ireq_op    = 4'b0100;
        ireq_a     = 12'h001;
        ireq_b     = 12'h001;
        @(negedge clk);
        ireq_valid = 1'b0;
        @(negedge clk);
        ireset = 1'b1;
        @(negedge clk);
        ireset = 1'b0;
        chk("wrst_valid", 32'(ores_valid), 32'd0);
        chk("wrst_count", 32'(oops_count), 32'd0);
        chk("wrst_ready", 32'(oreq_ready), 32'd1);
        chk("wrst_alu_op", 32'(oalu_op), 32'd0);
        chk("wrst_alu_a", 32'(oalu_a), 32'd0);
        chk("wrst_data", 32'(ores_data), 32'd0);
        issue("shf", 4'b0111, 12'h401, 12'h000);
        chk("shf_data", 32'(ores_data), 32'h802);
        chk("shf_psr", 32'(ores_psr), 32'b10000);
        @(negedge clk);
        chk("shf_count", 32'(oops_count), 32'd1);

        // Back-to-back ops; 2-bit counter wraps 1,2,3,0
        ireset = 1'b1;
        @(negedge clk);
        ireset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue("b2b", v_op[i], v_a[i], v_b[i]);
            chk("b2b_data", 32'(ores_data), 32'(v_data[i]));
            chk("b2b_psr", 32'(ores_psr), 32'(v_psr[i]));
            @(negedge clk);
            chk("b2b_count", 32'(oops_count), 32'(i + 1));
            chk("wrap_count", 32'(w_ops_count), 32'(v_wcnt[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Sequencer that sits between the instruction front end and the registered `ALU_32` datapath. It accepts one ALU request at a time over a valid/ready handshake and drives the ALU's operand and opcode inputs for exactly one clock edge. It then captures the ALU result and 5-bit PSR flags once they are valid and returns them over a second valid/ready handshake. It also keeps a wrapping completed-operation counter for performance monitoring.

## Interface
- `Bits`, 12, operand/result width; must match the ALU `Bits`
- `Ops`, 4, opcode width; must match the ALU `Ops`
- `CntW`, 16, width of the completed-operation counter
- `iclock`  in  1  clock; all logic is on the rising edge
- `ireset`  in  1  reset; one clock, synchronous, active-high
- `ireq_valid`  in  1  request valid
- `oreq_ready`  out  1  request ready
- `ireq_op`  in  Ops  requested opcode
- `ireq_a`, `ireq_b`  in  Bits  operands
- `oalu_op`  out  Ops  drives ALU `iop`
- `oalu_a`, `oalu_b`  out  Bits  drive ALU `in1`/`in2`
- `ialu_out`  in  Bits  ALU `out`
- `ialu_psr`  in  5  ALU `oPSR` {n,z,p,e,c}
- `ores_valid`  out  1  response valid
- `ires_ready`  in  1  response ready
- `ores_data`  out  Bits  captured result
- `ores_psr`  out  5  captured PSR
- `ores_err`  out  1  illegal opcode flag
- `oops_count`  out  CntW  completed responses, wrapping

## Operation
- Legal opcodes: ADD 4'b0100, MUL 4'b0101, CMP 4'b0110, SHF 4'b0111, ROT 4'b1000.
- NOP is 4'b0000. The ALU holds its value on NOP.
- States: IDLE, ISSUE, WAIT, RESP. Encoding is free.
- **IDLE:**
  - `oreq_ready`=1.
  - On `ireq_valid` && `oreq_ready`, latch op/a/b and go to ISSUE.
  - If the op is illegal and the trap is enabled (see Configuration), go directly to RESP instead.
- **ISSUE:**
  - `oalu_op`/`oalu_a`/`oalu_b` present the latched request. These are registered outputs.
  - Always go to WAIT.
- **WAIT:**
  - `oalu_op` returns to NOP.
  - Capture `ialu_out` into `ores_data` and `ialu_psr` into `ores_psr`.
  - Go to RESP.
- **RESP:**
  - `ores_valid`=1. `ores_data`, `ores_psr` and `ores_err` are held stable.
  - On `ires_ready`, increment `oops_count` (wraps `2^CntW-1`→0) and go to IDLE.
- `oreq_ready`=0 in every state other than IDLE. Requests presented outside IDLE are ignored, not queued.
- `oalu_op` is NOP in every state except ISSUE.
- `oalu_a`/`oalu_b` hold their last value outside ISSUE.
- Illegal opcode with the trap disabled: the request is issued unchanged and `ores_err`=0.
- Reset in any state, including ISSUE, WAIT or RESP:
  - The in-flight request is dropped and the state goes to IDLE.
  - `ores_valid`=0, `ores_data`=0, `ores_psr`=0, `ores_err`=0, `oops_count`=0.
  - `oalu_op`=NOP, `oalu_a`=0, `oalu_b`=0.
  - `oreq_ready`=1 after the reset edge.
- The ALU has no reset. The dispatcher never captures ALU output without first issuing.

## Timing
- Accept at edge E0 → ISSUE during cycle E0–E1. The ALU samples at E1.
- At E2, `ores_*` are registered and `ores_valid` rises.
- Latency from accept to response valid: 2 clocks.
- Trapped illegal op: `ores_valid` rises at E1, 1 clock after accept.
- A response consumed at edge Ek makes `oreq_ready` rise after Ek. The next accept is no earlier than Ek+1.
- Peak throughput: one op per 4 clocks with `ires_ready` held high.
- There is no combinational path from any input to any output.

## Configuration
- Macro: `ALU_DISPATCH_ILLEGAL_TRAP_EN`.
- **Defined:**
  - An opcode outside the legal set is never driven to the ALU.
  - The response is produced from IDLE in 1 clock with `ores_err`=1, `ores_data`=0, `ores_psr`=0.
  - The response still counts in `oops_count`.
- **Undefined:**
  - All opcodes follow the ISSUE/WAIT path.
  - `ores_err` is tied to 0.
  - Result and PSR are whatever the ALU holds, i.e. the previous result.

## Test plan
- Reset, then ADD a=12'h005 b=12'h003 with `ires_ready`=1 → `ores_valid` 2 clocks after accept, `ores_data`=12'h008, `ores_psr`=5'b01110, `oops_count`=1.
- ADD 12'h800+12'h800 → `ores_data`=12'h000, `ores_psr`=5'b01111 (carry set).
- MUL 12'h003×12'h004 with `ires_ready` held low for 5 clocks → `ores_valid`, `ores_data`=12'h00C and PSR held stable throughout; `oreq_ready`=0 until 1 clock after the handshake.
- Opcode 4'b1111 with trap defined → `oalu_op` stays 4'b0000, response after 1 clock with `ores_err`=1. Without the trap → `ores_err`=0 and `ores_data` equals the prior result.
- Assert `ireset` during WAIT → next cycle `ores_valid`=0, `oops_count`=0, `oreq_ready`=1. A following SHF on 12'h401 returns 12'h802.
- Preload-free wrap: with `CntW`=2, run 4 ops back-to-back → `oops_count` sequence 1,2,3,0.
